// File: rtl/associative_array_cache_pkg.sv
// associative_array_cache_pkg: default cache geometry, line/request types and address-split helpers.
package associative_array_cache_pkg;
  localparam int AAC_ADDR_W = 16;
  localparam int AAC_DATA_W = 32;
  localparam int AAC_NUM_WAYS = 4;
  localparam int AAC_NUM_SETS = 64;
  localparam int AAC_IDX_W = $clog2(AAC_NUM_SETS);
  localparam int AAC_TAG_W = AAC_ADDR_W - AAC_IDX_W;
  typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_e;
  typedef struct packed {
    logic valid;
    logic [AAC_TAG_W-1:0] tag;
    logic [AAC_DATA_W-1:0] data;
  } line_t;
  function automatic logic [AAC_IDX_W-1:0] get_index(input logic [AAC_ADDR_W-1:0] addr);
    return addr[AAC_IDX_W-1:0];
  endfunction
  function automatic logic [AAC_TAG_W-1:0] get_tag(input logic [AAC_ADDR_W-1:0] addr);
    return addr[AAC_ADDR_W-1:AAC_IDX_W];
  endfunction
endpackage

// File: rtl/associative_array_cache_lru.sv
// associative_array_cache_lru: per-set true-LRU ages (0 = MRU) with victim select and touch update.
module associative_array_cache_lru #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 64,
  localparam int WW = $clog2(NUM_WAYS),
  localparam int IW = $clog2(NUM_SETS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] set_i,
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic          touch_i,
  input  logic [WW-1:0] touch_way_i,
  output logic [WW-1:0] victim_o
);
  logic [WW-1:0] age_q [NUM_SETS][NUM_WAYS];
  logic [WW-1:0] max_age;
  // oldest valid way first, then let the lowest invalid way override it
  always_comb begin
    victim_o = '0;
    max_age = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (age_q[set_i][w] >= max_age) begin
        max_age = age_q[set_i][w];
        victim_o = WW'(w);
      end
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_i[w]) victim_o = WW'(w);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= WW'(w);
    end else if (touch_i) begin
      for (int w = 0; w < NUM_WAYS; w++)
        age_q[set_i][w] <= (WW'(w) == touch_way_i) ? '0 :
                           (age_q[set_i][w] < age_q[set_i][touch_way_i]) ? age_q[set_i][w] + WW'(1) :
                           age_q[set_i][w];
    end
  end
endmodule

// File: rtl/associative_array_cache.sv
// associative_array_cache: set-associative write-allocate tag/data store, 1-cycle latency, true LRU.
// Optional ASSOC_CACHE_STATS_EN adds saturating hit/miss counters; line layout follows the package geometry.
module associative_array_cache
  import associative_array_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = AAC_ADDR_W,
  parameter int DATA_WIDTH = AAC_DATA_W,
  parameter int NUM_WAYS = AAC_NUM_WAYS,
  parameter int NUM_SETS = AAC_NUM_SETS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_rw,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_rdata,
`ifdef ASSOC_CACHE_STATS_EN
  output logic [31:0]           o_hit_count,
  output logic [31:0]           o_miss_count,
`endif
  output logic                  o_hit
);
  localparam int WW = $clog2(NUM_WAYS);
  line_t lines_q [NUM_SETS][NUM_WAYS];
  line_t set_lines [NUM_WAYS];
  logic [AAC_IDX_W-1:0] idx;
  logic [AAC_TAG_W-1:0] tag_in;
  logic [NUM_WAYS-1:0] hit_vec, valid_vec;
  logic [WW-1:0] hit_way, victim, way_sel;
  logic hit, is_wr, acc, touch, hit_q, hit_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  req_e req;
  assign req = req_e'(i_rw);
  assign is_wr = req == REQ_WRITE;
  assign idx = get_index(i_addr);
  assign tag_in = get_tag(i_addr);
  assign o_ready = !rst;
  assign acc = i_valid && o_ready;
  always_comb begin
    set_lines = lines_q[idx];
    hit_vec = '0;
    valid_vec = '0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      valid_vec[w] = set_lines[w].valid;
      hit_vec[w] = set_lines[w].valid && set_lines[w].tag == tag_in;
      if (hit_vec[w]) hit_way = WW'(w);
    end
  end
  assign hit = |hit_vec;
  assign way_sel = hit ? hit_way : victim;
  assign touch = acc && (hit || is_wr);
  assign hit_d = hit;
  assign rdata_d = is_wr ? i_wdata : hit ? set_lines[hit_way].data : '0;
  associative_array_cache_lru #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) u_lru (
    .clk(clk),
    .rst(rst),
    .set_i(idx),
    .valid_i(valid_vec),
    .touch_i(touch),
    .touch_way_i(way_sel),
    .victim_o(victim)
  );
  // only valid bits are reset; tag/data contents are don't-care until a line is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          lines_q[s][w].valid <= 1'b0;
      hit_q <= 1'b0;
      rdata_q <= '0;
    end else if (acc) begin
      if (is_wr) lines_q[idx][way_sel] <= '{valid: 1'b1, tag: tag_in, data: i_wdata};
      hit_q <= hit_d;
      rdata_q <= rdata_d;
    end
  end
  assign o_hit = hit_q;
  assign o_rdata = rdata_q;
`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else if (acc) begin
      if (hit && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (!hit && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign o_hit_count = hit_cnt_q;
  assign o_miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_associative_array_cache.sv
// tb_associative_array_cache: directed and random checks against a recency-list reference model.
module tb_associative_array_cache;
  logic clk = 1'b0;
  logic rst, i_valid, i_rw, o_ready, o_hit;
  logic [15:0] i_addr;
  logic [31:0] i_wdata, o_rdata;
`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0] o_hit_count, o_miss_count;
`endif
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] res [64][$];
  logic [31:0] mem [logic [15:0]];

  associative_array_cache dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .i_rw(i_rw),
    .i_addr(i_addr),
    .i_wdata(i_wdata),
    .o_ready(o_ready),
    .o_rdata(o_rdata),
`ifdef ASSOC_CACHE_STATS_EN
    .o_hit_count(o_hit_count),
    .o_miss_count(o_miss_count),
`endif
    .o_hit(o_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < 64; s++) res[s].delete();
    mem.delete();
  endfunction

  // each set is a list of resident addresses, most recently used first, at most 4 long
  function automatic void model(input bit rw, input logic [15:0] a, input logic [31:0] d,
                                output bit h, output logic [31:0] r);
    int s;
    int pos;
    s = int'(a) % 64;
    pos = -1;
    for (int i = 0; i < res[s].size(); i++) if (res[s][i] == a) pos = i;
    h = pos >= 0;
    r = '0;
    if (!rw && !h) return;
    if (h) res[s].delete(pos);
    else if (res[s].size() == 4) void'(res[s].pop_back());
    res[s].push_front(a);
    if (rw) mem[a] = d;
    r = mem[a];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_in_reset", 32'(o_ready), 32'd0);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("ready_after_reset", 32'(o_ready), 32'd1);
    chk("hit_after_reset", 32'(o_hit), 32'd0);
    chk("rdata_after_reset", o_rdata, 32'd0);
  endtask

  task automatic op(input bit rw, input logic [15:0] a, input logic [31:0] d, input string nm);
    bit eh;
    logic [31:0] er;
    model(rw, a, d, eh, er);
    @(negedge clk);
    i_valid = 1'b1;
    i_rw = rw;
    i_addr = a;
    i_wdata = d;
    @(negedge clk);
    i_valid = 1'b0;
    chk({nm, "_hit"}, 32'(o_hit), 32'(eh));
    chk({nm, "_rdata"}, o_rdata, er);
  endtask

  initial begin
    bit eh;
    logic [31:0] er;
    logic [15:0] a;
    rst = 1'b1;
    i_valid = 1'b0;
    i_rw = 1'b0;
    i_addr = '0;
    i_wdata = '0;
    do_reset();
    op(0, 16'h1234, 32'h0, "rd_empty");
    chk("rd_empty_lit", 32'(o_hit), 32'd0);
    op(1, 16'h1234, 32'hDEADBEEF, "wr_miss");
    chk("wr_miss_lit", 32'(o_hit), 32'd0);
    op(0, 16'h1234, 32'h0, "rd_hit");
    chk("rd_hit_lit_hit", 32'(o_hit), 32'd1);
    chk("rd_hit_lit_data", o_rdata, 32'hDEADBEEF);
    op(1, 16'h1234, 32'h0BADF00D, "wr_hit");
    chk("wr_hit_lit", 32'(o_hit), 32'd1);
    op(0, 16'h1234, 32'h0, "rd_after_wr_hit");
    chk("rd_after_wr_hit_lit", o_rdata, 32'h0BADF00D);
    for (int i = 0; i < 6; i++) op(1, 16'(16'h0045 + 16'h0040 * i), 32'(i + 1), "conf_wr");
    op(0, 16'h0045, 32'h0, "conf_rd45");
    chk("conf_rd45_lit", 32'(o_hit), 32'd0);
    op(0, 16'h0085, 32'h0, "conf_rd85");
    chk("conf_rd85_lit", 32'(o_hit), 32'd0);
    for (int i = 2; i < 6; i++) begin
      op(0, 16'(16'h0045 + 16'h0040 * i), 32'h0, "conf_rd");
      chk("conf_rd_lit", o_rdata, 32'(i + 1));
    end
    do_reset();
    op(0, 16'h1234, 32'h0, "rd_after_reset2");
    chk("rd_after_reset2_lit", 32'(o_hit), 32'd0);
    for (int i = 0; i < 4; i++) op(1, 16'(16'h0045 + 16'h0040 * i), 32'(16 + i), "lru_fill");
    op(0, 16'h0045, 32'h0, "lru_touch");
    op(1, 16'h0145, 32'h55, "lru_alloc");
    op(0, 16'h0085, 32'h0, "lru_evicted");
    chk("lru_evicted_lit", 32'(o_hit), 32'd0);
    op(0, 16'h0045, 32'h0, "lru_kept");
    chk("lru_kept_lit", o_rdata, 32'd16);
    // back-to-back write then read of the same address
    model(1, 16'h2222, 32'hCAFE0001, eh, er);
    @(negedge clk);
    i_valid = 1'b1;
    i_rw = 1'b1;
    i_addr = 16'h2222;
    i_wdata = 32'hCAFE0001;
    @(negedge clk);
    chk("b2b_wr_hit", 32'(o_hit), 32'(eh));
    model(0, 16'h2222, 32'h0, eh, er);
    i_rw = 1'b0;
    i_wdata = 32'h0;
    @(negedge clk);
    i_valid = 1'b0;
    chk("b2b_rd_hit", 32'(o_hit), 32'd1);
    chk("b2b_rd_data", o_rdata, 32'hCAFE0001);
    repeat (3) @(negedge clk);
    chk("idle_hold_hit", 32'(o_hit), 32'd1);
    chk("idle_hold_data", o_rdata, 32'hCAFE0001);
    // reset during an in-flight write discards it
    @(negedge clk);
    rst = 1'b1;
    i_valid = 1'b1;
    i_rw = 1'b1;
    i_addr = 16'h3333;
    i_wdata = 32'h77777777;
    @(negedge clk);
    rst = 1'b0;
    i_valid = 1'b0;
    model_clear();
    chk("midreset_hit", 32'(o_hit), 32'd0);
    chk("midreset_rdata", o_rdata, 32'd0);
    op(0, 16'h3333, 32'h0, "midreset_rd");
    chk("midreset_rd_lit", 32'(o_hit), 32'd0);
    for (int i = 0; i < 100; i++) begin
      a = 16'(($urandom_range(0, 7) << 6) | $urandom_range(0, 3));
      op(1'($urandom_range(0, 1)), a, $urandom, "rand");
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
